// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: FIFO-buffered launcher for UART_driver.
// Pops one word at a time, raises a clean start edge and tracks the frame.
module uart_tx_feeder #(
    parameter int DEPTH         = 16,
    parameter int DATA_W        = 9,
    parameter int START_TIMEOUT = 64,
    parameter int GAP_CYCLES    = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [DATA_W-1:0]          in_data,
    output logic                       in_ready,
    output logic [DATA_W-1:0]          uart_data,
    output logic                       uart_start,
    input  logic                       uart_busy,
    input  logic                       uart_ready,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count,
    output logic                       tx_done,
    output logic                       timeout_err,
    input  logic                       clear_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int TW = $clog2(START_TIMEOUT + GAP_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_DONE = 2'd2,
        GAP       = 2'd3
    } state_t;

    state_t              state;
    logic [TW-1:0]       timer;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic                push;
    logic                pop;
    logic [CW-1:0]       count_next;

    // Handshake accept and launch (pop) decisions
    always_comb begin
        push = in_valid && in_ready;
        pop  = (state == IDLE) && (fifo_count != '0)
               && uart_ready && !uart_busy;
    end

    // Next occupancy from push/pop combination
    always_comb begin
        count_next = fifo_count;
        unique case ({push, pop})
            2'b10:   count_next = fifo_count + CW'(1);
            2'b01:   count_next = fifo_count - CW'(1);
            default: count_next = fifo_count;
        endcase
    end

    // FIFO storage write; contents need no reset
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    // Pointers, occupancy and registered ready
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            in_ready   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            fifo_count <= count_next;
            in_ready   <= (count_next < CW'(DEPTH));
        end
    end

    // Launch FSM; start goes high one cycle into LAUNCH so the
    // driver always sees at least one low cycle before the edge
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            uart_start  <= 1'b0;
            uart_data   <= '0;
            tx_done     <= 1'b0;
            timeout_err <= 1'b0;
            timer       <= '0;
        end else begin
            tx_done <= 1'b0;
            if (clear_err) begin
                timeout_err <= 1'b0;
            end
            unique case (state)
                IDLE: begin
                    uart_start <= 1'b0;
                    if (pop) begin
                        uart_data <= mem[rd_ptr];
                        timer     <= '0;
                        state     <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    if (uart_busy) begin
                        uart_start <= 1'b0;
                        state      <= WAIT_DONE;
                    end else if (timer == TW'(START_TIMEOUT - 1)) begin
                        uart_start  <= 1'b0;
                        timeout_err <= 1'b1;
                        timer       <= '0;
                        state       <= GAP;
                    end else begin
                        uart_start <= 1'b1;
                        timer      <= timer + TW'(1);
                    end
                end
                WAIT_DONE: begin
                    uart_start <= 1'b0;
                    if (!uart_busy && uart_ready) begin
                        tx_done <= 1'b1;
                        timer   <= '0;
                        state   <= GAP;
                    end
                end
                GAP: begin
                    uart_start <= 1'b0;
                    if (timer == TW'(GAP_CYCLES - 1)) begin
                        timer <= '0;
                        state <= IDLE;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                default: begin
                    uart_start <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule
